// File: rtl/entity_list_builder.sv
// entity_list_builder
// Walks the object map cell by cell in row-major order and builds the entity
// table for one frame. Each cell becomes one background entry written at the
// cell index. A moving object (type >= 4) also gets a foreground entry, which
// is appended after the COLS*ROWS background entries.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   next_screen         arm a rebuild (latched if it arrives while a build runs)
//   new_state           game state committed; starts an armed build
//   address_read_om     object-map read address (= current cell index)
//   data_read_om        map word one cycle after address: {type[2:0], shift[5:0], dir[1:0]}
//   address_write_ent   entity-table write address
//   data_write_ent      {code[2:0], row_px, col_px}
//   wren                entity-table write strobe
//   entities_number     entries written in the current or last frame
//   busy                high from ARMED through the final write
//   done                one-cycle pulse after the last write
//   overflow            sticky per frame: a foreground entry was dropped
//   state_dbg           current FSM state encoding
//
// Handshake: there is no back-pressure. Each wren cycle is one complete write
// that the entity table accepts unconditionally; data_read_om is trusted one
// cycle after address_read_om is presented.
module entity_list_builder #(
  parameter int COLS   = 10,
  parameter int ROWS   = 10,
  parameter int CELL   = 48,
  parameter int POS_W  = 9,
  parameter int ENT_AW = 8,
  parameter int MAP_AW = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   next_screen,
  input  logic                   new_state,
  output logic [MAP_AW-1:0]      address_read_om,
  input  logic [10:0]            data_read_om,
  output logic [ENT_AW-1:0]      address_write_ent,
  output logic [3+2*POS_W-1:0]   data_write_ent,
  output logic                   wren,
  output logic [ENT_AW-1:0]      entities_number,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [2:0]             state_dbg
);

  localparam int NCELLS = COLS * ROWS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    READ    = 3'd2,
    EMIT_BG = 3'd3,
    EMIT_FG = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [MAP_AW-1:0]   cell_q, row_q, col_q;
  logic [ENT_AW-1:0]   ent_q;
  logic                ovf_q;
  logic                rearm_q;
  logic [10:0]         word_q;

  logic [10:0]         word;
  logic [2:0]          typ;
  logic [1:0]          dir;
  logic [POS_W-1:0]    shamt;
  logic [POS_W-1:0]    base_row, base_col;
  logic [POS_W-1:0]    srow, scol;
  logic [2:0]          single_code;
  logic                last_cell;
  logic                start, advance, fg_write, drop;

  // The map word is only guaranteed in the cycle after READ, so the
  // foreground cycle works from the copy captured during EMIT_BG.
  assign word  = (state_q == EMIT_FG) ? word_q : data_read_om;
  assign typ   = word[10:8];
  assign dir   = word[1:0];
  assign shamt = POS_W'(word[7:2]);

  assign base_row = POS_W'(row_q * CELL);
  assign base_col = POS_W'(col_q * CELL);

  // Offsets wrap modulo 2^POS_W by construction of the POS_W-bit adders.
  always_comb begin
    srow = base_row;
    scol = base_col;
    case (dir)
      2'b00:   scol = base_col - shamt;
      2'b01:   scol = base_col + shamt;
      2'b10:   srow = base_row - shamt;
      default: srow = base_row + shamt;
    endcase
  end

  always_comb begin
    case (typ)
      3'd0:    single_code = 3'b000;
      3'd1:    single_code = 3'b100;
      3'd2:    single_code = 3'b011;
      default: single_code = 3'b101;
    endcase
  end

  assign last_cell = (cell_q == MAP_AW'(NCELLS - 1));

  always_comb begin
    state_d           = state_q;
    wren              = 1'b0;
    address_write_ent = '0;
    data_write_ent    = '0;
    start             = 1'b0;
    advance           = 1'b0;
    fg_write          = 1'b0;
    drop              = 1'b0;
    case (state_q)
      IDLE:  if (next_screen) state_d = ARMED;
      ARMED: if (new_state) begin
        state_d = READ;
        start   = 1'b1;
      end
      READ:  state_d = EMIT_BG;
      EMIT_BG: begin
        wren              = 1'b1;
        address_write_ent = ENT_AW'(cell_q);
        if (typ < 3'd4) begin
          data_write_ent = {single_code, srow, scol};
          advance        = 1'b1;
        end else begin
          data_write_ent = {(typ >= 3'd6) ? 3'b100 : 3'b000, base_row, base_col};
          state_d        = EMIT_FG;
        end
      end
      EMIT_FG: begin
        // The last table slot is never used, so the count stays below ENT_DEPTH.
        if (ent_q != '1) begin
          wren              = 1'b1;
          address_write_ent = ent_q;
          data_write_ent    = {(typ == 3'd4 || typ == 3'd7) ? 3'b010 : 3'b001, srow, scol};
          fg_write          = 1'b1;
        end else begin
          drop = 1'b1;
        end
        advance = 1'b1;
      end
      FINISH: state_d = (rearm_q || next_screen) ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) state_d = last_cell ? FINISH : READ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cell_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ent_q   <= '0;
      ovf_q   <= 1'b0;
      rearm_q <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EMIT_BG) word_q <= data_read_om;

      if (start) begin
        cell_q <= '0;
        row_q  <= '0;
        col_q  <= '0;
        ent_q  <= ENT_AW'(NCELLS);
        ovf_q  <= 1'b0;
      end else begin
        if (advance && !last_cell) begin
          cell_q <= cell_q + 1'b1;
          if (col_q == MAP_AW'(COLS - 1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        if (fg_write) ent_q <= ent_q + 1'b1;
        if (drop)     ovf_q <= 1'b1;
      end

      // A request during an active build is held and re-arms after FINISH.
      if (state_q == FINISH)
        rearm_q <= 1'b0;
      else if (next_screen && (state_q == READ || state_q == EMIT_BG || state_q == EMIT_FG))
        rearm_q <= 1'b1;
    end
  end

  assign address_read_om = cell_q;
  assign entities_number = ent_q;
  assign overflow        = ovf_q;
  assign done            = (state_q == FINISH);
  assign busy            = (state_q == ARMED) || (state_q == READ) ||
                           (state_q == EMIT_BG) || (state_q == EMIT_FG);
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_entity_list_builder.sv
module tb_entity_list_builder;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic next_screen = 1'b0;
  logic new_state = 1'b0;

  // instance a: default parameters
  logic [6:0]  ra_addr;
  logic [10:0] ra_data;
  logic [7:0]  wa_addr;
  logic [20:0] wa_data;
  logic        wa_en;
  logic [7:0]  a_num;
  logic        a_busy, a_done, a_ovf;
  logic [2:0]  a_state;

  // instance b: 128-entry table to exercise overflow
  logic [6:0]  rb_addr;
  logic [10:0] rb_data;
  logic [6:0]  wb_addr;
  logic [20:0] wb_data;
  logic        wb_en;
  logic [6:0]  b_num;
  logic        b_busy, b_done, b_ovf;
  logic [2:0]  b_state;

  entity_list_builder dut_a (
    .clk(clk), .reset(reset), .next_screen(next_screen), .new_state(new_state),
    .address_read_om(ra_addr), .data_read_om(ra_data),
    .address_write_ent(wa_addr), .data_write_ent(wa_data), .wren(wa_en),
    .entities_number(a_num), .busy(a_busy), .done(a_done), .overflow(a_ovf),
    .state_dbg(a_state)
  );

  entity_list_builder #(.ENT_AW(7)) dut_b (
    .clk(clk), .reset(reset), .next_screen(next_screen), .new_state(new_state),
    .address_read_om(rb_addr), .data_read_om(rb_data),
    .address_write_ent(wb_addr), .data_write_ent(wb_data), .wren(wb_en),
    .entities_number(b_num), .busy(b_busy), .done(b_done), .overflow(b_ovf),
    .state_dbg(b_state)
  );

  // object map: synchronous read, one cycle latency
  logic [10:0] map_mem [128];
  always @(posedge clk) begin
    ra_data <= map_mem[ra_addr];
    rb_data <= map_mem[rb_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // entity-table capture (scoreboard storage)
  logic [20:0] ent_a [256];
  logic [20:0] ent_b [128];
  int wa_cnt = 0;
  int wb_cnt = 0;
  always @(negedge clk) begin
    if (wa_en) begin
      ent_a[wa_addr] = wa_data;
      wa_cnt++;
    end
    if (wb_en) begin
      ent_b[wb_addr] = wb_data;
      wb_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_map(input logic [10:0] w);
    for (int i = 0; i < 128; i++) map_mem[i] = w;
  endtask

  // new_state pulse then wait for done; lat = cycles from start edge to done, -1 on timeout
  task automatic start_and_wait(output int lat);
    int s;
    new_state = 1'b1;
    tick();
    new_state = 1'b0;
    s = cyc;
    lat = -1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (a_done) begin
        lat = cyc - s;
        break;
      end
    end
  endtask

  task automatic run_build(output int lat);
    next_screen = 1'b1;
    tick();
    next_screen = 1'b0;
    start_and_wait(lat);
  endtask

  int lat, a0, b0;

  initial begin
    fill_map(11'd0);

    // reset state
    #1;
    chk("rst_wren", wa_en, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_num", a_num, 0);
    chk("rst_addr", wa_addr, 0);
    chk("rst_data", wa_data, 0);
    chk("rst_state", a_state, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // next_screen and new_state together in IDLE only arm
    a0 = wa_cnt;
    next_screen = 1'b1;
    new_state   = 1'b1;
    tick();
    next_screen = 1'b0;
    new_state   = 1'b0;
    chk("both_armed", a_state, 1);
    tick(); tick(); tick();
    chk("armed_hold", a_state, 1);
    chk("armed_busy", a_busy, 1);
    chk("armed_nowr", wa_cnt - a0, 0);

    // all type 0, shift 0
    start_and_wait(lat);
    chk("t0_lat", lat, 200);
    chk("t0_cnt", wa_cnt - a0, 100);
    chk("t0_num", a_num, 100);
    chk("t0_e0", ent_a[0], {3'b000, 9'd0, 9'd0});
    chk("t0_e23", ent_a[23], {3'b000, 9'd96, 9'd144});
    chk("t0_e99", ent_a[99], {3'b000, 9'd432, 9'd432});
    chk("t0_busy", a_busy, 0);
    chk("t0_ovf", a_ovf, 0);
    tick();
    chk("t0_done_pulse", a_done, 0);
    chk("t0_idle", a_state, 0);

    // cell 0 type 4 shift 5 down, rest type 1
    fill_map({3'd1, 6'd0, 2'b00});
    map_mem[0] = {3'd4, 6'd5, 2'b11};
    a0 = wa_cnt;
    run_build(lat);
    chk("t1_lat", lat, 201);
    chk("t1_cnt", wa_cnt - a0, 101);
    chk("t1_num", a_num, 101);
    chk("t1_bg0", ent_a[0], {3'b000, 9'd0, 9'd0});
    chk("t1_fg100", ent_a[100], {3'b010, 9'd5, 9'd0});
    chk("t1_e1", ent_a[1], {3'b100, 9'd0, 9'd48});
    chk("t1_e57", ent_a[57], {3'b100, 9'd240, 9'd336});

    // wrap and the other directions / single codes
    fill_map(11'd0);
    map_mem[0] = {3'd0, 6'd3, 2'b10};
    map_mem[1] = {3'd2, 6'd7, 2'b00};
    map_mem[2] = {3'd3, 6'd1, 2'b01};
    run_build(lat);
    chk("t2_wrap", ent_a[0], {3'b000, 9'd509, 9'd0});
    chk("t2_left", ent_a[1], {3'b011, 9'd0, 9'd41});
    chk("t2_right", ent_a[2], {3'b101, 9'd0, 9'd97});
    chk("t2_num", a_num, 100);

    // 40 cells type 5: b overflows
    fill_map(11'd0);
    for (int i = 0; i < 40; i++) map_mem[i] = {3'd5, 6'd0, 2'b00};
    a0 = wa_cnt;
    b0 = wb_cnt;
    run_build(lat);
    chk("t3_lat", lat, 240);
    chk("t3_a_num", a_num, 140);
    chk("t3_a_ovf", a_ovf, 0);
    chk("t3_a_cnt", wa_cnt - a0, 140);
    chk("t3_b_num", b_num, 127);
    chk("t3_b_ovf", b_ovf, 1);
    chk("t3_b_cnt", wb_cnt - b0, 127);
    chk("t3_b_bg0", ent_b[0], {3'b000, 9'd0, 9'd0});
    chk("t3_b_fg100", ent_b[100], {3'b001, 9'd0, 9'd0});
    chk("t3_b_fg126", ent_b[126], {3'b001, 9'd96, 9'd288});
    chk("t3_a_fg139", ent_a[139], {3'b001, 9'd144, 9'd432});

    // types 6 and 7; b overflow cleared on new build
    fill_map(11'd0);
    map_mem[0] = {3'd6, 6'd0, 2'b00};
    map_mem[1] = {3'd7, 6'd2, 2'b01};
    run_build(lat);
    chk("t4_lat", lat, 202);
    chk("t4_bg0", ent_a[0], {3'b100, 9'd0, 9'd0});
    chk("t4_fg100", ent_a[100], {3'b001, 9'd0, 9'd0});
    chk("t4_bg1", ent_a[1], {3'b100, 9'd0, 9'd48});
    chk("t4_fg101", ent_a[101], {3'b010, 9'd0, 9'd50});
    chk("t4_num", a_num, 102);
    chk("t4_b_ovf", b_ovf, 0);

    // reset mid-build aborts
    fill_map(11'd0);
    next_screen = 1'b1;
    tick();
    next_screen = 1'b0;
    new_state = 1'b1;
    tick();
    new_state = 1'b0;
    for (int i = 0; i < 49; i++) tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_wren", wa_en, 0);
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_state", a_state, 0);
    tick();
    reset = 1'b0;
    a0 = wa_cnt;
    for (int i = 0; i < 20; i++) tick();
    new_state = 1'b1;
    tick();
    new_state = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    chk("rst_nowr", wa_cnt - a0, 0);
    chk("rst_idle", a_state, 0);
    chk("rst_num0", a_num, 0);

    // next_screen during a build re-arms after done
    a0 = wa_cnt;
    next_screen = 1'b1;
    tick();
    next_screen = 1'b0;
    new_state = 1'b1;
    tick();
    new_state = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    next_screen = 1'b1;
    tick();
    next_screen = 1'b0;
    lat = -1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (a_done) begin
        lat = i;
        break;
      end
    end
    chk("rearm_first_done", a_done, 1);
    tick();
    chk("rearm_state", a_state, 1);
    chk("rearm_busy", a_busy, 1);
    start_and_wait(lat);
    chk("rearm_lat", lat, 200);
    chk("rearm_cnt", wa_cnt - a0, 200);
    tick();
    chk("rearm_idle", a_state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
